ps2_key_decoder: RTL



---
 rtl/ps2_key_decoder_pkg.sv | 19 +
 rtl/ps2_scan_ascii.sv | 71 +++++++
 rtl/ps2_key_decoder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ps2_key_decoder_pkg.sv
// Shared constants and FSM encoding for the PS/2 key decoder.
package ps2_key_decoder_pkg;

   localparam logic [7:0] PS2_BRK     = 8'hF0;
   localparam logic [7:0] PS2_EXT     = 8'hE0;

   localparam logic [7:0] SC_SPACE    = 8'h29;
   localparam logic [7:0] SC_ENTER    = 8'h5A;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_ENTER = 8'h0D;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_POP    = 2'd1,
      ST_SETTLE = 2'd2,
      ST_DECODE = 2'd3
   } state_e;

endpackage

// File: rtl/ps2_scan_ascii.sv
// Combinational PS/2 set-2 scan code to ASCII lookup (letters, digits,
// space, enter). Unmapped codes give 8'h00.
module ps2_scan_ascii
   import ps2_key_decoder_pkg::*;
#(
   parameter bit LOWERCASE = 1'b1
) (
   input  logic [7:0] scan_i,
   output logic [7:0] ascii_o
);

   localparam logic [7:0] LETTER_BASE = LOWERCASE ? 8'h61 : 8'h41;

   logic       is_letter;
   logic [7:0] letter_idx;

   // Letters resolve to an alphabet index; everything else maps directly.
   always_comb begin
      is_letter  = 1'b1;
      letter_idx = 8'd0;
      ascii_o    = 8'h00;
      case (scan_i)
         8'h1C: letter_idx = 8'd0;   // a
         8'h32: letter_idx = 8'd1;   // b
         8'h21: letter_idx = 8'd2;   // c
         8'h23: letter_idx = 8'd3;   // d
         8'h24: letter_idx = 8'd4;   // e
         8'h2B: letter_idx = 8'd5;   // f
         8'h34: letter_idx = 8'd6;   // g
         8'h33: letter_idx = 8'd7;   // h
         8'h43: letter_idx = 8'd8;   // i
         8'h3B: letter_idx = 8'd9;   // j
         8'h42: letter_idx = 8'd10;  // k
         8'h4B: letter_idx = 8'd11;  // l
         8'h3A: letter_idx = 8'd12;  // m
         8'h31: letter_idx = 8'd13;  // n
         8'h44: letter_idx = 8'd14;  // o
         8'h4D: letter_idx = 8'd15;  // p
         8'h15: letter_idx = 8'd16;  // q
         8'h2D: letter_idx = 8'd17;  // r
         8'h1B: letter_idx = 8'd18;  // s
         8'h2C: letter_idx = 8'd19;  // t
         8'h3C: letter_idx = 8'd20;  // u
         8'h2A: letter_idx = 8'd21;  // v
         8'h1D: letter_idx = 8'd22;  // w
         8'h22: letter_idx = 8'd23;  // x
         8'h35: letter_idx = 8'd24;  // y
         8'h1A: letter_idx = 8'd25;  // z
         default: begin
            is_letter = 1'b0;
            case (scan_i)
               8'h45:    ascii_o = 8'h30;
               8'h16:    ascii_o = 8'h31;
               8'h1E:    ascii_o = 8'h32;
               8'h26:    ascii_o = 8'h33;
               8'h25:    ascii_o = 8'h34;
               8'h2E:    ascii_o = 8'h35;
               8'h36:    ascii_o = 8'h36;
               8'h3D:    ascii_o = 8'h37;
               8'h3E:    ascii_o = 8'h38;
               8'h46:    ascii_o = 8'h39;
               SC_SPACE: ascii_o = ASCII_SPACE;
               SC_ENTER: ascii_o = ASCII_ENTER;
               default:  ascii_o = 8'h00;
            endcase
         end
      endcase
      if (is_letter) ascii_o = LETTER_BASE + letter_idx;
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// Pops scan-code bytes from the PS/2 receiver FIFO, tracks E0/F0 prefixes
// and presents the current key, its ASCII value, held state and a press count.
module ps2_key_decoder
   import ps2_key_decoder_pkg::*;
#(
   parameter int CNT_W     = 8,
   parameter bit LOWERCASE = 1'b1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [7:0]       kb_data,
   input  logic             kb_ready,
   input  logic             kb_overflow,
   output logic             kb_nextdata_n,
   output logic [7:0]       scancode,
   output logic [7:0]       ascii,
   output logic             key_down,
   output logic             key_ext,
   output logic [CNT_W-1:0] press_count,
   output logic             ovf_sticky
);

   state_e           state_q, state_d;
   logic [7:0]       byte_q, byte_d;
   logic             brk_q, brk_d;
   logic             ext_q, ext_d;
   logic [7:0]       scancode_q, scancode_d;
   logic [7:0]       ascii_q, ascii_d;
   logic             key_down_q, key_down_d;
   logic             key_ext_q, key_ext_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [7:0]       lut_ascii;
   logic             same_key;

   ps2_scan_ascii #(.LOWERCASE(LOWERCASE)) u_lut (
      .scan_i  (byte_q),
      .ascii_o (lut_ascii)
   );

   // Same physical key as the one currently latched (code and E0 prefix).
   assign same_key = (byte_q == scancode_q) && (ext_q == key_ext_q);

   // State and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         byte_q     <= 8'h00;
         brk_q      <= 1'b0;
         ext_q      <= 1'b0;
         scancode_q <= 8'h00;
         ascii_q    <= 8'h00;
         key_down_q <= 1'b0;
         key_ext_q  <= 1'b0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_q     <= byte_d;
         brk_q      <= brk_d;
         ext_q      <= ext_d;
         scancode_q <= scancode_d;
         ascii_q    <= ascii_d;
         key_down_q <= key_down_d;
         key_ext_q  <= key_ext_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
      end
   end

   // Pop/settle/decode sequencing and the make/break/prefix decode rules.
   always_comb begin
      state_d       = state_q;
      byte_d        = byte_q;
      brk_d         = brk_q;
      ext_d         = ext_q;
      scancode_d    = scancode_q;
      ascii_d       = ascii_q;
      key_down_d    = key_down_q;
      key_ext_d     = key_ext_q;
      cnt_d         = cnt_q;
      ovf_d         = ovf_q | kb_overflow;
      kb_nextdata_n = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (kb_ready) begin
               byte_d  = kb_data;
               state_d = ST_POP;
            end
         end
         ST_POP: begin
            kb_nextdata_n = 1'b0;
            state_d       = ST_SETTLE;
         end
         // Give the receiver a cycle to update its read pointer and ready.
         ST_SETTLE: state_d = ST_DECODE;
         ST_DECODE: begin
            state_d = ST_IDLE;
            if (byte_q == PS2_EXT) begin
               ext_d = 1'b1;
            end else if (byte_q == PS2_BRK) begin
               brk_d = 1'b1;
            end else if (brk_q) begin
               if (same_key) key_down_d = 1'b0;
               brk_d = 1'b0;
               ext_d = 1'b0;
            end else begin
               // A held key re-sending its make code is typematic repeat.
               if (!(key_down_q && same_key)) begin
                  scancode_d = byte_q;
                  ascii_d    = ext_q ? 8'h00 : lut_ascii;
                  key_ext_d  = ext_q;
                  key_down_d = 1'b1;
                  cnt_d      = cnt_q + CNT_W'(1);
               end
               ext_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign scancode    = scancode_q;
   assign ascii       = ascii_q;
   assign key_down    = key_down_q;
   assign key_ext     = key_ext_q;
   assign press_count = cnt_q;
   assign ovf_sticky  = ovf_q;

endmodule
